// File: rtl/fighter_action_ctrl.sv
// fighter_action_ctrl -- per-frame action sequencer for one fighter.
//
// Decodes held USB keycodes into idle/walk/crouch/jump and into punch/kick
// attacks. Each attack runs STARTUP -> ACTIVE -> RECOVER on 8-bit down-counters.
// Being struck (Hit_In) forces HITSTUN from any state and emits knockback away
// from the facing direction.
//
// Optional feature: define FIGHTER_CANCEL_EN so that a kick press during an
// active punch cancels straight into kick startup.
//
// Ports
//   frame_clk              clock, one cycle per video frame
//   Reset                  synchronous, active-low reset
//   keycode_0..keycode_3   currently held keycodes (0x00 = none)
//   Hit_In                 fighter struck this frame
//   Facing_Right           fighter faces +X (sampled every frame)
//   Action[2:0]            0 idle, 1 walk, 2 crouch, 3 jump, 4 punch, 5 kick, 6 hitstun
//   Phase[1:0]             0 none, 1 startup, 2 active, 3 recover
//   Frame_Idx[2:0]         frames spent in the current state, saturating at 7
//   Attack_Active          hitbox live
//   Move_Enable            movement block may act on A/D/S/W
//   Knockback[7:0]         signed X displacement per frame
module fighter_action_ctrl #(
  parameter int PUNCH_STARTUP  = 3,
  parameter int PUNCH_ACTIVE   = 4,
  parameter int PUNCH_RECOVER  = 6,
  parameter int KICK_STARTUP   = 5,
  parameter int KICK_ACTIVE    = 4,
  parameter int KICK_RECOVER   = 9,
  parameter int HITSTUN_FRAMES = 12,
  parameter int KNOCKBACK_PX   = 2
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [7:0] keycode_0,
  input  logic [7:0] keycode_1,
  input  logic [7:0] keycode_2,
  input  logic [7:0] keycode_3,
  input  logic       Hit_In,
  input  logic       Facing_Right,
  output logic [2:0] Action,
  output logic [1:0] Phase,
  output logic [2:0] Frame_Idx,
  output logic       Attack_Active,
  output logic       Move_Enable,
  output logic [7:0] Knockback
);

  typedef enum logic [2:0] {S_IDLE, S_STARTUP, S_ACTIVE, S_RECOVER, S_HITSTUN} state_t;
  typedef enum logic [1:0] {MV_NONE, MV_PUNCH, MV_KICK} move_t;

  // Counter load values are length-1: the state exits on the frame the counter reads 0.
  localparam logic [7:0] PS_LD  = 8'(PUNCH_STARTUP - 1);
  localparam logic [7:0] PA_LD  = 8'(PUNCH_ACTIVE - 1);
  localparam logic [7:0] PR_LD  = 8'(PUNCH_RECOVER - 1);
  localparam logic [7:0] KS_LD  = 8'(KICK_STARTUP - 1);
  localparam logic [7:0] KA_LD  = 8'(KICK_ACTIVE - 1);
  localparam logic [7:0] KR_LD  = 8'(KICK_RECOVER - 1);
  localparam logic [7:0] HS_LD  = 8'(HITSTUN_FRAMES - 1);
  localparam logic [7:0] KB_POS = 8'(KNOCKBACK_PX);
  localparam logic [7:0] KB_NEG = 8'(-KNOCKBACK_PX);

  function automatic logic is_held(input logic [7:0] k0, input logic [7:0] k1,
                                   input logic [7:0] k2, input logic [7:0] k3,
                                   input logic [7:0] code);
    return (k0 == code) || (k1 == code) || (k2 == code) || (k3 == code);
  endfunction

  state_t     state, state_n;
  move_t      move, move_n;
  logic [7:0] cnt, cnt_n;
  logic       prev_j, prev_k;
  logic       key_a, key_d, key_s, key_w, key_j, key_k;
  logic       j_edge, k_edge, enter;
  logic [2:0] idle_act, act_n;
  logic [1:0] phase_n;

  assign key_a  = is_held(keycode_0, keycode_1, keycode_2, keycode_3, 8'h04);
  assign key_d  = is_held(keycode_0, keycode_1, keycode_2, keycode_3, 8'h07);
  assign key_s  = is_held(keycode_0, keycode_1, keycode_2, keycode_3, 8'h16);
  assign key_w  = is_held(keycode_0, keycode_1, keycode_2, keycode_3, 8'h1A);
  assign key_j  = is_held(keycode_0, keycode_1, keycode_2, keycode_3, 8'h0D);
  assign key_k  = is_held(keycode_0, keycode_1, keycode_2, keycode_3, 8'h0E);
  assign j_edge = key_j & ~prev_j;
  assign k_edge = key_k & ~prev_k;

  always_comb begin
    state_n = state;
    move_n  = move;
    cnt_n   = cnt;
    if (Hit_In) begin
      // Hit wins over everything, including a same-frame press and hitstun itself.
      state_n = S_HITSTUN;
      move_n  = MV_NONE;
      cnt_n   = HS_LD;
    end else begin
      case (state)
        S_IDLE: begin
          if (j_edge) begin
            state_n = S_STARTUP; move_n = MV_PUNCH; cnt_n = PS_LD;
          end else if (k_edge) begin
            state_n = S_STARTUP; move_n = MV_KICK;  cnt_n = KS_LD;
          end
        end
        S_STARTUP: begin
          if (cnt == 8'd0) begin
            state_n = S_ACTIVE;
            cnt_n   = (move == MV_KICK) ? KA_LD : PA_LD;
          end else cnt_n = cnt - 8'd1;
        end
        S_ACTIVE: begin
`ifdef FIGHTER_CANCEL_EN
          if (move == MV_PUNCH && k_edge) begin
            state_n = S_STARTUP; move_n = MV_KICK; cnt_n = KS_LD;
          end else
`endif
          if (cnt == 8'd0) begin
            state_n = S_RECOVER;
            cnt_n   = (move == MV_KICK) ? KR_LD : PR_LD;
          end else cnt_n = cnt - 8'd1;
        end
        S_RECOVER, S_HITSTUN: begin
          if (cnt == 8'd0) begin
            state_n = S_IDLE; move_n = MV_NONE;
          end else cnt_n = cnt - 8'd1;
        end
        default: begin
          state_n = S_IDLE; move_n = MV_NONE; cnt_n = 8'd0;
        end
      endcase
    end
  end

  // Hit_In re-entering HITSTUN counts as an entry even though the state is unchanged.
  assign enter = Hit_In || (state_n != state);

  // Idle pose priority: crouch > jump > walk.
  assign idle_act = key_s ? 3'd2 : key_w ? 3'd3 : (key_a | key_d) ? 3'd1 : 3'd0;

  always_comb begin
    act_n   = 3'd0;
    phase_n = 2'd0;
    case (state_n)
      S_IDLE:    act_n = idle_act;
      S_STARTUP: begin act_n = (move_n == MV_KICK) ? 3'd5 : 3'd4; phase_n = 2'd1; end
      S_ACTIVE:  begin act_n = (move_n == MV_KICK) ? 3'd5 : 3'd4; phase_n = 2'd2; end
      S_RECOVER: begin act_n = (move_n == MV_KICK) ? 3'd5 : 3'd4; phase_n = 2'd3; end
      S_HITSTUN: act_n = 3'd6;
      default:   act_n = 3'd0;
    endcase
  end

  always_ff @(posedge frame_clk) begin
    if (!Reset) begin
      state         <= S_IDLE;
      move          <= MV_NONE;
      cnt           <= 8'd0;
      prev_j        <= 1'b0;
      prev_k        <= 1'b0;
      Action        <= 3'd0;
      Phase         <= 2'd0;
      Frame_Idx     <= 3'd0;
      Attack_Active <= 1'b0;
      Move_Enable   <= 1'b1;
      Knockback     <= 8'd0;
    end else begin
      state         <= state_n;
      move          <= move_n;
      cnt           <= cnt_n;
      prev_j        <= key_j;
      prev_k        <= key_k;
      Action        <= act_n;
      Phase         <= phase_n;
      Frame_Idx     <= enter ? 3'd0 : (Frame_Idx == 3'd7) ? 3'd7 : Frame_Idx + 3'd1;
      Attack_Active <= (state_n == S_ACTIVE);
      Move_Enable   <= (state_n == S_IDLE);
      Knockback     <= (state_n != S_HITSTUN) ? 8'd0 : Facing_Right ? KB_NEG : KB_POS;
    end
  end

endmodule

// File: tb/tb_fighter_action_ctrl.sv
module tb_fighter_action_ctrl;

  localparam int PS = 3, PA = 4, PR = 6, KS = 5, KA = 4, KR = 9, HF = 12, KB = 2;
`ifdef FIGHTER_CANCEL_EN
  localparam bit CANCEL = 1'b1;
`else
  localparam bit CANCEL = 1'b0;
`endif

  logic       frame_clk = 1'b0;
  logic       Reset;
  logic [7:0] keycode_0, keycode_1, keycode_2, keycode_3;
  logic       Hit_In, Facing_Right;
  logic [2:0] Action;
  logic [1:0] Phase;
  logic [2:0] Frame_Idx;
  logic       Attack_Active, Move_Enable;
  logic [7:0] Knockback;

  fighter_action_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset),
    .keycode_0(keycode_0), .keycode_1(keycode_1), .keycode_2(keycode_2), .keycode_3(keycode_3),
    .Hit_In(Hit_In), .Facing_Right(Facing_Right),
    .Action(Action), .Phase(Phase), .Frame_Idx(Frame_Idx),
    .Attack_Active(Attack_Active), .Move_Enable(Move_Enable), .Knockback(Knockback)
  );

  always #5 frame_clk = ~frame_clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the fighter is idle, in an attack of a given kind, or in hitstun,
  // tracked only as "frames since the episode began". Phase and frame index
  // are derived from that age against the phase lengths.
  int   m_mode = 0;   // 0 idle, 1 attack, 2 hitstun
  int   m_kind = 4;   // 4 punch, 5 kick
  int   m_age  = 0;
  bit   m_pj = 0, m_pk = 0, m_face = 0;
  int   m_idle_act = 0;

  function automatic bit held(input logic [7:0] code);
    return keycode_0 == code || keycode_1 == code || keycode_2 == code || keycode_3 == code;
  endfunction

  function automatic int su_len(input int kind); return kind == 5 ? KS : PS; endfunction
  function automatic int ac_len(input int kind); return kind == 5 ? KA : PA; endfunction
  function automatic int tot_len(input int kind);
    return kind == 5 ? KS + KA + KR : PS + PA + PR;
  endfunction

  task automatic model_edge();
    bit j, k, je, ke;
    j = held(8'h0D); k = held(8'h0E);
    je = j && !m_pj; ke = k && !m_pk;
    if (!Reset) begin
      m_mode = 0; m_age = 0; m_pj = 0; m_pk = 0; m_idle_act = 0; m_face = 0;
      return;
    end
    if (Hit_In) begin
      m_mode = 2; m_age = 0;
    end else if (m_mode == 0) begin
      if (je)      begin m_mode = 1; m_kind = 4; m_age = 0; end
      else if (ke) begin m_mode = 1; m_kind = 5; m_age = 0; end
      else m_age++;
    end else if (m_mode == 1) begin
      if (CANCEL && m_kind == 4 && ke && m_age >= PS && m_age < PS + PA) begin
        m_kind = 5; m_age = 0;
      end else begin
        m_age++;
        if (m_age >= tot_len(m_kind)) begin m_mode = 0; m_age = 0; end
      end
    end else begin
      m_age++;
      if (m_age >= HF) begin m_mode = 0; m_age = 0; end
    end
    m_idle_act = held(8'h16) ? 2 : held(8'h1A) ? 3 : (held(8'h04) || held(8'h07)) ? 1 : 0;
    m_face = Facing_Right;
    m_pj = j; m_pk = k;
  endtask

  task automatic model_compare();
    int act, ph, fi;
    logic [7:0] kb;
    act = 0; ph = 0; fi = m_age; kb = 8'h00;
    if (m_mode == 0) act = m_idle_act;
    else if (m_mode == 2) begin
      act = 6;
      kb = m_face ? 8'(256 - KB) : 8'(KB);
    end else begin
      act = m_kind;
      if (m_age < su_len(m_kind)) begin ph = 1; fi = m_age; end
      else if (m_age < su_len(m_kind) + ac_len(m_kind)) begin ph = 2; fi = m_age - su_len(m_kind); end
      else begin ph = 3; fi = m_age - su_len(m_kind) - ac_len(m_kind); end
    end
    if (fi > 7) fi = 7;
    chk("model_action", 32'(Action), 32'(act));
    chk("model_phase", 32'(Phase), 32'(ph));
    chk("model_frame_idx", 32'(Frame_Idx), 32'(fi));
    chk("model_attack_active", 32'(Attack_Active), 32'(ph == 2));
    chk("model_move_enable", 32'(Move_Enable), 32'(m_mode == 0));
    chk("model_knockback", 32'(Knockback), 32'(kb));
  endtask

  // One frame: the DUT and the model both consume the inputs present at the edge.
  task automatic step();
    @(posedge frame_clk);
    model_edge();
    #1;
    model_compare();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic keys(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic [7:0] d);
    keycode_0 = a; keycode_1 = b; keycode_2 = c; keycode_3 = d;
  endtask

  initial begin
    Reset = 1'b0; Hit_In = 1'b0; Facing_Right = 1'b0;
    keys(8'h00, 8'h00, 8'h00, 8'h00);

    // Reset state
    run(2);
    chk("rst_action", 32'(Action), 32'd0);
    chk("rst_phase", 32'(Phase), 32'd0);
    chk("rst_move_en", 32'(Move_Enable), 32'd1);
    chk("rst_knockback", 32'(Knockback), 32'd0);
    chk("rst_attack", 32'(Attack_Active), 32'd0);
    Reset = 1'b1;
    run(3);

    // Held punch key: full punch, no retrigger
    keys(8'h00, 8'h00, 8'h0D, 8'h00);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 1)  begin chk("p_n1_action", 32'(Action), 32'd4); chk("p_n1_phase", 32'(Phase), 32'd1); end
      if (k == 3)  chk("p_n3_phase", 32'(Phase), 32'd1);
      if (k == 4)  begin chk("p_n4_attack", 32'(Attack_Active), 32'd1); chk("p_n4_move_en", 32'(Move_Enable), 32'd0); end
      if (k == 7)  chk("p_n7_attack", 32'(Attack_Active), 32'd1);
      if (k == 8)  begin chk("p_n8_phase", 32'(Phase), 32'd3); chk("p_n8_attack", 32'(Attack_Active), 32'd0); end
      if (k == 13) chk("p_n13_phase", 32'(Phase), 32'd3);
      if (k == 14) begin chk("p_n14_action", 32'(Action), 32'd0); chk("p_n14_fidx", 32'(Frame_Idx), 32'd0); end
      if (k == 20) chk("p_no_retrigger", 32'(Action), 32'd0);
    end
    keys(8'h00, 8'h00, 8'h00, 8'h00);
    run(2);

    // Kick, hit during ACTIVE, re-hit at hitstun frame 5
    Facing_Right = 1'b1;
    keys(8'h0E, 8'h00, 8'h00, 8'h00);
    step();
    chk("k_action", 32'(Action), 32'd5);
    keys(8'h00, 8'h00, 8'h00, 8'h00);
    run(5);
    chk("k_active_phase", 32'(Phase), 32'd2);
    Hit_In = 1'b1;
    step();
    Hit_In = 1'b0;
    chk("hs_action", 32'(Action), 32'd6);
    chk("hs_knockback", 32'(Knockback), 32'h0FE);
    chk("hs_attack_off", 32'(Attack_Active), 32'd0);
    run(5);
    chk("hs_fidx5", 32'(Frame_Idx), 32'd5);
    Hit_In = 1'b1;
    step();
    Hit_In = 1'b0;
    chk("rehit_fidx", 32'(Frame_Idx), 32'd0);
    run(3);
    Facing_Right = 1'b0;
    step();
    chk("hs_face_left_kb", 32'(Knockback), 32'h002);
    Facing_Right = 1'b1;
    run(7);
    chk("rehit_still_hs", 32'(Action), 32'd6);
    chk("rehit_fidx_sat", 32'(Frame_Idx), 32'd7);
    step();
    chk("rehit_exit", 32'(Action), 32'd0);
    chk("rehit_exit_kb", 32'(Knockback), 32'd0);

    // Hit and punch edge in the same frame
    keys(8'h00, 8'h0D, 8'h00, 8'h00);
    Hit_In = 1'b1;
    step();
    Hit_In = 1'b0;
    chk("hitj_action", 32'(Action), 32'd6);
    run(13);
    chk("hitj_no_punch", 32'(Action), 32'd0);
    keys(8'h00, 8'h00, 8'h00, 8'h00);
    run(1);

    // Idle poses and priorities
    keys(8'h16, 8'h07, 8'h00, 8'h00);
    step();
    chk("crouch_action", 32'(Action), 32'd2);
    chk("crouch_move_en", 32'(Move_Enable), 32'd1);
    keys(8'h16, 8'h07, 8'h0D, 8'h00);
    step();
    chk("crouch_punch_action", 32'(Action), 32'd4);
    chk("crouch_punch_move_en", 32'(Move_Enable), 32'd0);
    run(14);
    keys(8'h1A, 8'h16, 8'h00, 8'h00); step(); chk("s_over_w", 32'(Action), 32'd2);
    keys(8'h1A, 8'h04, 8'h00, 8'h00); step(); chk("w_over_a", 32'(Action), 32'd3);
    keys(8'h00, 8'h00, 8'h00, 8'h04); step(); chk("walk_a", 32'(Action), 32'd1);
    keys(8'h00, 8'h00, 8'h00, 8'h00); step(); chk("idle_none", 32'(Action), 32'd0);

    // Kick press at punch ACTIVE frame 2
    keys(8'h0D, 8'h00, 8'h00, 8'h00);
    run(6);
    chk("c_phase", 32'(Phase), 32'd2);
    chk("c_fidx", 32'(Frame_Idx), 32'd2);
    keys(8'h00, 8'h0E, 8'h00, 8'h00);
    step();
`ifdef FIGHTER_CANCEL_EN
    chk("cancel_action", 32'(Action), 32'd5);
    chk("cancel_phase", 32'(Phase), 32'd1);
`else
    chk("nocancel_action", 32'(Action), 32'd4);
    chk("nocancel_phase", 32'(Phase), 32'd2);
`endif
    keys(8'h00, 8'h00, 8'h00, 8'h00);
    run(20);

    // Presses during an attack are ignored; reset aborts an attack
    keys(8'h0D, 8'h00, 8'h00, 8'h00);
    step();
    keys(8'h0D, 8'h0E, 8'h00, 8'h00);
    step();
    chk("k_in_startup_ignored", 32'(Action), 32'd4);
    keys(8'h00, 8'h00, 8'h00, 8'h00);
    run(7);
    keys(8'h0D, 8'h00, 8'h00, 8'h00);
    step();
    chk("j_in_recover_ignored", 32'(Phase), 32'd3);
    Reset = 1'b0;
    step();
    chk("midrst_action", 32'(Action), 32'd0);
    chk("midrst_move_en", 32'(Move_Enable), 32'd1);
    Reset = 1'b1;
    keys(8'h00, 8'h00, 8'h00, 8'h00);
    step();
    chk("post_rst_idle", 32'(Phase), 32'd0);
    run(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
